// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types: IF/ID register layout, fetch FSM states
// and the NOP that fills an empty IF/ID slot.
package rv32_pkg;

    // Fetch controller states: idle/issuing, waiting on a response, or
    // discarding a response that a redirect made stale.
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    // IF/ID pipeline register contents seen by decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam if_id_t      IF_ID_NOP = '{pc: 32'h0000_0000, inst: NOP_INST};

    // Clears the byte-offset bits so a fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight,
// loads IF/ID for decode and parks one response in an inline skid buffer
// while decode is stalled. Redirect overrides everything else.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output if_id_t      if_id,
    output logic        if_id_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_inst;

    logic         rsp_in_wait;
    logic         rsp_direct;
    logic         rsp_to_buf;
    logic         buf_drain;
    logic         req_fire;
    logic [31:0]  redirect_target;

    assign redirect_target = word_align(redirect_pc);
    assign imem_req_addr   = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // A response only belongs to us while we are waiting for it.
    assign rsp_in_wait = (state == FS_WAIT) && imem_rsp_valid;
    assign rsp_direct  = !redirect && rsp_in_wait && !stall && !buf_valid;
    assign rsp_to_buf  = !redirect && rsp_in_wait && stall && !buf_valid;
    assign buf_drain   = !redirect && !stall && buf_valid;

    // Request is withdrawn on redirect and held off while the buffer is full.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!redirect && !buf_valid) begin
            case (state)
                FS_REQ:  imem_req_valid = 1'b1;
                FS_WAIT: imem_req_valid = imem_rsp_valid && !stall;
                default: imem_req_valid = 1'b0;
            endcase
        end
    end

    // Fetch FSM: tracks the single outstanding request and stale drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FS_REQ;
        end else if (redirect) begin
            case (state)
                FS_WAIT: state <= imem_rsp_valid ? FS_REQ : FS_DROP;
                FS_DROP: state <= imem_rsp_valid ? FS_REQ : FS_DROP;
                default: state <= FS_REQ;
            endcase
        end else begin
            case (state)
                FS_REQ: begin
                    if (req_fire) state <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) state <= req_fire ? FS_WAIT : FS_REQ;
                end
                FS_DROP: begin
                    if (imem_rsp_valid) state <= FS_REQ;
                end
                default: state <= FS_REQ;
            endcase
        end
    end

    // Program counter: redirect target, else advance on each accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    // Address of the fetch in flight, paired with its response later.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_pc <= pc;
        end
    end

    // Skid buffer occupancy: filled on a stalled response, emptied on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (redirect) begin
            buf_valid <= 1'b0;
        end else if (rsp_to_buf) begin
            buf_valid <= 1'b1;
        end else if (buf_drain) begin
            buf_valid <= 1'b0;
        end
    end

    // Skid buffer payload; only meaningful while buf_valid is set.
    always_ff @(posedge clk) begin
        if (rsp_to_buf) begin
            buf_pc   <= req_pc;
            buf_inst <= imem_rsp_data;
        end
    end

    // IF/ID register: redirect, stall, buffer, direct response, bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id       <= IF_ID_NOP;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            if_id       <= IF_ID_NOP;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id       <= if_id;
            if_id_valid <= if_id_valid;
        end else if (buf_valid) begin
            if_id       <= '{pc: buf_pc, inst: buf_inst};
            if_id_valid <= 1'b1;
        end else if (rsp_direct) begin
            if_id       <= '{pc: req_pc, inst: imem_rsp_data};
            if_id_valid <= 1'b1;
        end else begin
            if_id       <= IF_ID_NOP;
            if_id_valid <= 1'b0;
        end
    end

endmodule
